// File: rtl/rx_ip_pkg.sv
// rtl/rx_ip_pkg.sv - shared constants, FSM encoding and checksum helper for the IPv4 RX dispatcher
package rx_ip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_DISCARD = 2'd3
    } rx_state_t;

    localparam logic [3:0]  IP_VER4    = 4'd4;
    localparam logic [3:0]  IHL_MIN    = 4'd5;
    localparam logic [7:0]  PROTO_UDP  = 8'h11;
    localparam logic [7:0]  PROTO_ICMP = 8'h01;
    localparam logic [31:0] BCAST_IP   = 32'hFFFF_FFFF;

    // 16-bit one's-complement addition with end-around carry
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/rx_ip_csum.sv
// rtl/rx_ip_csum.sv - byte-fed one's-complement header accumulator (built only with RX_IP_CSUM_CHECK_EN)
module rx_ip_csum
    import rx_ip_pkg::*;
(
    input  logic        RX_CLK,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] sum
);

    logic [15:0] acc;
    logic [7:0]  hi;
    logic        phase;
    logic [15:0] acc_base;
    logic        phase_base;

    // clr and en may coincide: the byte on the clearing cycle starts the new sum
    assign acc_base   = clr ? 16'd0 : acc;
    assign phase_base = clr ? 1'b0 : phase;
    assign sum        = (en && phase_base) ? ones_add(acc_base, {hi, data}) : acc_base;

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            acc   <= 16'd0;
            hi    <= 8'd0;
            phase <= 1'b0;
        end else if (en) begin
            if (!phase_base) begin
                hi    <= data;
                phase <= 1'b1;
                acc   <= acc_base;
            end else begin
                acc   <= sum;
                phase <= 1'b0;
            end
        end else if (clr) begin
            acc   <= 16'd0;
            phase <= 1'b0;
        end
    end

endmodule

// File: rtl/rx_ip_dispatch.sv
// rtl/rx_ip_dispatch.sv - IPv4 RX header qualifier and UDP/ICMP payload dispatcher; RX_IP_CSUM_CHECK_EN adds header checksum check
module rx_ip_dispatch
    import rx_ip_pkg::*;
#(
    parameter int             OCT   = 8,
    parameter logic [OCT-1:0] UDP   = PROTO_UDP,
    parameter logic [OCT-1:0] ICMP  = PROTO_ICMP,
    parameter int             CNT_W = 16
)(
    input  logic             RX_CLK,
    input  logic             rst,
    input  logic [31:0]      ip_addr,
    input  logic             rx_payload_ipv4,
    input  logic [OCT-1:0]   rx_payload,
    output logic [31:0]      rx_src_ip,
    output logic [OCT-1:0]   rx_proto,
    output logic             udp_valid,
    output logic             icmp_valid,
    output logic [OCT-1:0]   pl_data,
    output logic             pl_sof,
    output logic             pl_eof,
    output logic             pl_err,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    rx_state_t   state;
    logic        armed;
    logic [5:0]  hcnt;
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [15:0] tot_len;
    logic [15:0] pcnt;
    logic        mf;
    logic [12:0] frag;
    logic [31:0] src;
    logic [31:0] dst;
    logic        first;

    logic [5:0]  hdr_len;
    logic [5:0]  hdr_end;
    logic [15:0] plen;
    logic [31:0] dst_now;
    logic        csum_ok;
    logic        accept;

    assign hdr_len = {ihl, 2'b00};
    // an illegal IHL still walks through the fixed header so the verdict sees full fields
    assign hdr_end = (ihl < IHL_MIN) ? 6'd19 : hdr_len - 6'd1;
    assign plen    = tot_len - {10'd0, hdr_len};
    assign dst_now = (hcnt == 6'd19) ? {dst[23:0], rx_payload} : dst;

`ifdef RX_IP_CSUM_CHECK_EN
    logic [15:0] csum_sum;

    rx_ip_csum u_csum (
        .RX_CLK (RX_CLK),
        .rst    (rst),
        .clr    (state == ST_IDLE),
        .en     (rx_payload_ipv4 && (state == ST_IDLE || state == ST_HDR)),
        .data   (rx_payload),
        .sum    (csum_sum)
    );

    assign csum_ok = (csum_sum == 16'hFFFF);
`else
    assign csum_ok = 1'b1;
`endif

    assign accept = (ver == IP_VER4) && (ihl >= IHL_MIN) && (tot_len >= {10'd0, hdr_len})
                 && !mf && (frag == 13'd0)
                 && (dst_now == ip_addr || dst_now == BCAST_IP)
                 && (rx_proto == UDP || rx_proto == ICMP) && csum_ok;

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state      <= ST_IDLE;
            armed      <= 1'b0;
            hcnt       <= 6'd0;
            ver        <= 4'd0;
            ihl        <= 4'd0;
            tot_len    <= 16'd0;
            pcnt       <= 16'd0;
            mf         <= 1'b0;
            frag       <= 13'd0;
            src        <= 32'd0;
            dst        <= 32'd0;
            first      <= 1'b0;
            rx_src_ip  <= 32'd0;
            rx_proto   <= '0;
            udp_valid  <= 1'b0;
            icmp_valid <= 1'b0;
            pl_data    <= '0;
            pl_sof     <= 1'b0;
            pl_eof     <= 1'b0;
            pl_err     <= 1'b0;
            pkt_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            // a header may only start once valid has been seen low since reset
            armed      <= armed | ~rx_payload_ipv4;
            udp_valid  <= 1'b0;
            icmp_valid <= 1'b0;
            pl_sof     <= 1'b0;
            pl_eof     <= 1'b0;
            pl_err     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rx_payload_ipv4) begin
                        if (armed) begin
                            ver   <= rx_payload[7:4];
                            ihl   <= rx_payload[3:0];
                            hcnt  <= 6'd1;
                            state <= ST_HDR;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end
                end

                ST_HDR: begin
                    if (!rx_payload_ipv4) begin
                        drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, ~&drop_cnt};
                        state    <= ST_IDLE;
                    end else begin
                        hcnt <= hcnt + 6'd1;
                        case (hcnt)
                            6'd2:  tot_len[15:8] <= rx_payload;
                            6'd3:  tot_len[7:0]  <= rx_payload;
                            6'd6:  begin
                                mf          <= rx_payload[5];
                                frag[12:8]  <= rx_payload[4:0];
                            end
                            6'd7:  frag[7:0] <= rx_payload;
                            6'd9:  rx_proto  <= rx_payload;
                            6'd12, 6'd13, 6'd14, 6'd15: src <= {src[23:0], rx_payload};
                            6'd16, 6'd17, 6'd18, 6'd19: dst <= {dst[23:0], rx_payload};
                            default: ;
                        endcase
                        if (hcnt == hdr_end) begin
                            if (accept) begin
                                rx_src_ip <= src;
                                if (plen == 16'd0) begin
                                    pkt_cnt <= pkt_cnt + {{(CNT_W-1){1'b0}}, ~&pkt_cnt};
                                    state   <= ST_DISCARD;
                                end else begin
                                    pcnt  <= plen;
                                    first <= 1'b1;
                                    state <= ST_PAYLOAD;
                                end
                            end else begin
                                drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, ~&drop_cnt};
                                state    <= ST_DISCARD;
                            end
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (!rx_payload_ipv4) begin
                        pl_err   <= 1'b1;
                        drop_cnt <= drop_cnt + {{(CNT_W-1){1'b0}}, ~&drop_cnt};
                        state    <= ST_IDLE;
                    end else begin
                        pl_data    <= rx_payload;
                        udp_valid  <= (rx_proto == UDP);
                        icmp_valid <= (rx_proto == ICMP);
                        pl_sof     <= first;
                        first      <= 1'b0;
                        pcnt       <= pcnt - 16'd1;
                        if (pcnt == 16'd1) begin
                            pl_eof  <= 1'b1;
                            pkt_cnt <= pkt_cnt + {{(CNT_W-1){1'b0}}, ~&pkt_cnt};
                            state   <= ST_DISCARD;
                        end
                    end
                end

                ST_DISCARD: begin
                    if (!rx_payload_ipv4) state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_ip_dispatch.sv
// tb/tb_rx_ip_dispatch.sv - self-checking bench for rx_ip_dispatch against a frame-level reference model
module tb_rx_ip_dispatch;

    logic        RX_CLK = 1'b0;
    logic        rst;
    logic [31:0] ip_addr;
    logic        rx_payload_ipv4;
    logic [7:0]  rx_payload;
    logic [31:0] rx_src_ip;
    logic [7:0]  rx_proto;
    logic        udp_valid, icmp_valid;
    logic [7:0]  pl_data;
    logic        pl_sof, pl_eof, pl_err;
    logic [15:0] pkt_cnt, drop_cnt;

    rx_ip_dispatch dut (
        .RX_CLK          (RX_CLK),
        .rst             (rst),
        .ip_addr         (ip_addr),
        .rx_payload_ipv4 (rx_payload_ipv4),
        .rx_payload      (rx_payload),
        .rx_src_ip       (rx_src_ip),
        .rx_proto        (rx_proto),
        .udp_valid       (udp_valid),
        .icmp_valid      (icmp_valid),
        .pl_data         (pl_data),
        .pl_sof          (pl_sof),
        .pl_eof          (pl_eof),
        .pl_err          (pl_err),
        .pkt_cnt         (pkt_cnt),
        .drop_cnt        (drop_cnt)
    );

    always #5 RX_CLK = ~RX_CLK;

    int errors = 0;
    int checks = 0;
    int exp_pkt = 0;
    int exp_drop = 0;

    logic [7:0]  m_data[$];
    logic [1:0]  m_port[$];
    logic        m_sof[$];
    logic        m_eof[$];
    int          m_err = 0;
    int          m_stray = 0;

    always @(negedge RX_CLK) begin
        if (udp_valid || icmp_valid) begin
            m_data.push_back(pl_data);
            m_port.push_back({icmp_valid, udp_valid});
            m_sof.push_back(pl_sof);
            m_eof.push_back(pl_eof);
        end else if (pl_sof || pl_eof) begin
            m_stray++;
        end
        if (pl_err) m_err++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0]  frame[$];
    logic [3:0]  p_ver, p_ihl;
    logic [15:0] p_tl, p_frag;
    logic [7:0]  p_proto;
    logic [31:0] p_dst;
    logic        p_mf, p_flip;
    int          p_pad, p_cut;

    task automatic set_def();
        p_ver = 4'd4; p_ihl = 4'd5; p_tl = 16'd28; p_proto = 8'h11; p_dst = ip_addr;
        p_mf = 1'b0; p_frag = 16'd0; p_pad = 0; p_cut = -1; p_flip = 1'b0;
    endtask

    function automatic logic [15:0] sum_words(input int hl);
        logic [16:0] s;
        logic [15:0] acc;
        acc = 16'd0;
        for (int w = 0; w < hl; w += 2) begin
            s   = {1'b0, acc} + {1'b0, frame[w], frame[w+1]};
            acc = s[15:0] + {15'd0, s[16]};
        end
        return acc;
    endfunction

    task automatic build();
        int hl;
        logic [15:0] cs;
        logic [31:0] src;
        hl  = int'(p_ihl) * 4;
        src = $urandom;
        frame.delete();
        frame.push_back({p_ver, p_ihl});
        frame.push_back(8'h00);
        frame.push_back(p_tl[15:8]);
        frame.push_back(p_tl[7:0]);
        frame.push_back(8'($urandom));
        frame.push_back(8'($urandom));
        frame.push_back({2'b00, p_mf, p_frag[12:8]});
        frame.push_back(p_frag[7:0]);
        frame.push_back(8'd64);
        frame.push_back(p_proto);
        frame.push_back(8'h00);
        frame.push_back(8'h00);
        for (int i = 3; i >= 0; i--) frame.push_back(src[i*8 +: 8]);
        for (int i = 3; i >= 0; i--) frame.push_back(p_dst[i*8 +: 8]);
        while (frame.size() < hl) frame.push_back(8'($urandom));
        cs = ~sum_words(hl) ^ {15'd0, p_flip};
        frame[10] = cs[15:8];
        frame[11] = cs[7:0];
        while (frame.size() < int'(p_tl)) frame.push_back(8'($urandom));
        for (int i = 0; i < p_pad; i++) frame.push_back(8'h00);
        if (p_cut >= 0) while (frame.size() > p_cut) void'(frame.pop_back());
    endtask

    // reference model: decide from the frame bytes alone, then drive and compare
    task automatic run_frame(input string tag);
        logic [7:0]  exp_pl[$];
        logic [1:0]  exp_port;
        logic [15:0] tl;
        logic [31:0] dst, src;
        logic [7:0]  proto;
        bit          acc, complete;
        int          len, hl, plen, nfw, n;
        len = frame.size();
        hl  = int'(frame[0][3:0]) * 4;
        acc = 0; complete = 0; proto = 8'h00; src = 32'd0;
        if (len >= hl && hl >= 20) begin
            tl    = {frame[2], frame[3]};
            proto = frame[9];
            src   = {frame[12], frame[13], frame[14], frame[15]};
            dst   = {frame[16], frame[17], frame[18], frame[19]};
            acc   = (frame[0][7:4] == 4'd4) && (int'(tl) >= hl) && (frame[6][5] == 1'b0)
                 && ({frame[6][4:0], frame[7]} == 13'd0)
                 && (dst == ip_addr || dst == 32'hFFFF_FFFF)
                 && (proto == 8'h11 || proto == 8'h01);
`ifdef RX_IP_CSUM_CHECK_EN
            acc = acc && (sum_words(hl) == 16'hFFFF);
`endif
        end
        exp_port = (proto == 8'h11) ? 2'b01 : 2'b10;
        if (!acc) begin
            exp_drop++;
        end else begin
            plen     = int'(tl) - hl;
            nfw      = (len - hl < plen) ? len - hl : plen;
            complete = (len - hl >= plen);
            for (int i = 0; i < nfw; i++) exp_pl.push_back(frame[hl+i]);
            if (complete) exp_pkt++; else exp_drop++;
        end

        m_data.delete(); m_port.delete(); m_sof.delete(); m_eof.delete();
        m_err = 0; m_stray = 0;
        foreach (frame[i]) begin
            @(posedge RX_CLK); #1;
            rx_payload_ipv4 = 1'b1;
            rx_payload      = frame[i];
        end
        @(posedge RX_CLK); #1;
        rx_payload_ipv4 = 1'b0;
        repeat (3) @(posedge RX_CLK);
        #1;

        chk({tag, ".nbytes"}, 32'(m_data.size()), 32'(exp_pl.size()));
        n = (m_data.size() < exp_pl.size()) ? m_data.size() : exp_pl.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, ".data"}, 32'(m_data[i]), 32'(exp_pl[i]));
            chk({tag, ".port"}, 32'(m_port[i]), 32'(exp_port));
            chk({tag, ".sof"},  32'(m_sof[i]),  32'(i == 0));
            chk({tag, ".eof"},  32'(m_eof[i]),  32'(complete && i == exp_pl.size() - 1));
        end
        chk({tag, ".err"},   32'(m_err),   32'(acc && !complete));
        chk({tag, ".stray"}, 32'(m_stray), 32'd0);
        chk({tag, ".pkt"},   32'(pkt_cnt),  32'(exp_pkt));
        chk({tag, ".drop"},  32'(drop_cnt), 32'(exp_drop));
        if (acc) begin
            chk({tag, ".src"},   rx_src_ip,      src);
            chk({tag, ".proto"}, 32'(rx_proto), 32'(proto));
        end
    endtask

    initial begin
        int sel;
        ip_addr         = 32'h0A00_0002;
        rst             = 1'b1;
        rx_payload_ipv4 = 1'b0;
        rx_payload      = 8'h00;
        repeat (3) @(posedge RX_CLK);
        #1 rst = 1'b0;
        repeat (2) @(posedge RX_CLK);
        #1;
        chk("rst.udp_valid",  32'(udp_valid),  32'd0);
        chk("rst.icmp_valid", 32'(icmp_valid), 32'd0);
        chk("rst.pl_data",    32'(pl_data),    32'd0);
        chk("rst.sof_eof",    32'({pl_sof, pl_eof, pl_err}), 32'd0);
        chk("rst.pkt_cnt",    32'(pkt_cnt),    32'd0);
        chk("rst.drop_cnt",   32'(drop_cnt),   32'd0);
        chk("rst.src_ip",     rx_src_ip,       32'd0);
        chk("rst.proto",      32'(rx_proto),   32'd0);

        set_def(); p_pad = 18; build(); run_frame("udp_pad");
        set_def(); p_dst = 32'h0A00_0009; build(); run_frame("dst_miss");
        set_def(); p_dst = 32'hFFFF_FFFF; build(); run_frame("bcast");
        set_def(); p_ihl = 4'd6; p_proto = 8'h01; p_tl = 16'd32; build(); run_frame("icmp_opt");
        set_def(); p_mf = 1'b1; build(); run_frame("mf");
        set_def(); p_frag = 16'h0010; build(); run_frame("frag");
        set_def(); p_tl = 16'd20; p_pad = 26; build(); run_frame("empty");
        set_def(); p_cut = 23; build(); run_frame("trunc");
        set_def(); build(); run_frame("after_trunc");
        set_def(); build(); run_frame("csum_good");
        set_def(); p_flip = 1'b1; build(); run_frame("csum_bad");
        set_def(); p_proto = 8'h06; build(); run_frame("tcp");
        set_def(); p_cut = 12; build(); run_frame("hdr_cut");

        for (int k = 0; k < 14; k++) begin
            set_def();
            p_ihl = 4'($urandom_range(5, 7));
            p_tl  = 16'(int'(p_ihl) * 4 + $urandom_range(0, 20));
            sel   = $urandom_range(0, 2);
            p_proto = (sel == 0) ? 8'h11 : (sel == 1) ? 8'h01 : 8'h06;
            sel   = $urandom_range(0, 3);
            p_dst = (sel == 0) ? 32'h0A00_0009 : (sel == 1) ? 32'hFFFF_FFFF : ip_addr;
            p_mf  = ($urandom_range(0, 7) == 0);
            p_frag = ($urandom_range(0, 7) == 0) ? 16'h0020 : 16'h0000;
            p_pad = $urandom_range(0, 10);
            p_flip = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) p_cut = $urandom_range(8, int'(p_tl));
            build();
            run_frame("rand");
        end

        // reset in the middle of a frame; the tail must be absorbed, not parsed
        set_def(); build();
        m_data.delete(); m_err = 0; m_stray = 0;
        foreach (frame[i]) begin
            @(posedge RX_CLK); #1;
            rst             = (i == 10);
            rx_payload_ipv4 = 1'b1;
            rx_payload      = frame[i];
        end
        @(posedge RX_CLK); #1;
        rst = 1'b0;
        rx_payload_ipv4 = 1'b0;
        repeat (3) @(posedge RX_CLK);
        #1;
        exp_pkt = 0; exp_drop = 0;
        chk("midrst.nbytes", 32'(m_data.size()), 32'd0);
        chk("midrst.err",    32'(m_err + m_stray), 32'd0);
        chk("midrst.pkt",    32'(pkt_cnt),  32'd0);
        chk("midrst.drop",   32'(drop_cnt), 32'd0);
        set_def(); build(); run_frame("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
